// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
//   - CLKS_PER_BIT_DEF : default system clocks per serial bit (115200 baud at 100 MHz)
//   - DATA_BITS        : payload bits per frame
//   - rx_state_e       : receiver state encoding
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_DEF = 868;
    localparam int unsigned DATA_BITS        = 8;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StStart     = 3'd1,
        StData      = 3'd2,
        StStop      = 3'd3,
        StBreakWait = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk     : sampling clock
//   reset   : synchronous, active-low reset; both flops load RESET_VAL
//   i_async : asynchronous input
//   o_sync  : synchronised output, two cycles of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. Detects the start bit, samples each bit at mid-period,
// reassembles bytes LSB first and flags bad stop bits.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low reset
//   rx          : asynchronous serial line, idle high
//   o_data_byte : last correctly framed byte, held until the next good frame
//   rx_done     : one-cycle strobe, o_data_byte is new
//   framing_err : one-cycle strobe, stop bit sampled low
//   rx_busy     : high whenever the receiver is not idle
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_data_byte,
    output logic                 rx_done,
    output logic                 framing_err,
    output logic                 rx_busy
);

    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    rx_state_e            r_state, w_state_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic [BIT_W-1:0]     r_bit, w_bit_d;
    logic [DATA_BITS-1:0] r_shift, w_shift_d;
    logic [DATA_BITS-1:0] r_data, w_data_d;
    logic                 r_done, w_done_d;
    logic                 r_ferr, w_ferr_d;

    // Idle-high line: reset the chain to 1 so reset release never looks like a start bit.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .reset   (reset),
        .i_async (rx),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            r_data  <= w_data_d;
            r_done  <= w_done_d;
            r_ferr  <= w_ferr_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_data_d  = r_data;
        w_done_d  = 1'b0;
        w_ferr_d  = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                w_bit_d = '0;
                if (!w_rx_s) w_state_d = StStart;
            end
            StStart: begin
                if (r_cnt == CNT_HALF) begin
                    // Line back high at the start-bit midpoint: a glitch, not a frame.
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = w_rx_s ? StIdle : StData;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StData: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_d          = '0;
                    w_shift_d[r_bit] = w_rx_s;
                    if (r_bit == BIT_LAST) w_state_d = StStop;
                    else                   w_bit_d   = r_bit + 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StStop: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_d = '0;
                    if (w_rx_s) begin
                        w_data_d  = r_shift;
                        w_done_d  = 1'b1;
                        w_state_d = StIdle;
                    end else begin
                        w_ferr_d  = 1'b1;
                        w_state_d = StBreakWait;
                    end
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StBreakWait: begin
                // Hold off until the line idles so a break is not taken as a start bit.
                w_cnt_d = '0;
                if (w_rx_s) w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
                w_bit_d   = '0;
            end
        endcase
    end

    assign o_data_byte = r_data;
    assign rx_done     = r_done;
    assign framing_err = r_ferr;
    assign rx_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: one instance at the default baud setting
// and one at CLKS_PER_BIT=4, each with its own reset and serial line.
module tb_uart_receiver;

    localparam int CPB_B  = 868;
    localparam int CPB_S  = 4;
    localparam int HALF_B = (CPB_B - 1) / 2;
    localparam int HALF_S = (CPB_S - 1) / 2;

    logic       clk = 1'b0;
    logic       rst_n  [2];
    logic       rx_pin [2];
    logic [7:0] data_o [2];
    logic       done_o [2];
    logic       ferr_o [2];
    logic       busy_o [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int   done_rise [2] = '{0, 0};
    int   done_hi   [2] = '{0, 0};
    int   ferr_rise [2] = '{0, 0};
    int   ferr_hi   [2] = '{0, 0};
    int   rise_cyc  [2] = '{0, 0};
    int   prev_cyc  [2] = '{0, 0};
    int   start_cyc [2] = '{0, 0};
    int   both_cnt      = 0;
    logic done_prev [2] = '{1'b0, 1'b0};
    logic ferr_prev [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(
        .CLKS_PER_BIT (CPB_B)
    ) u_dut_big (
        .clk         (clk),
        .reset       (rst_n[0]),
        .rx          (rx_pin[0]),
        .o_data_byte (data_o[0]),
        .rx_done     (done_o[0]),
        .framing_err (ferr_o[0]),
        .rx_busy     (busy_o[0])
    );

    uart_receiver #(
        .CLKS_PER_BIT (CPB_S)
    ) u_dut_small (
        .clk         (clk),
        .reset       (rst_n[1]),
        .rx          (rx_pin[1]),
        .o_data_byte (data_o[1]),
        .rx_done     (done_o[1]),
        .framing_err (ferr_o[1]),
        .rx_busy     (busy_o[1])
    );

    // Strobe monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done_o[i]) begin
                done_hi[i]++;
                if (!done_prev[i]) begin
                    done_rise[i]++;
                    prev_cyc[i] = rise_cyc[i];
                    rise_cyc[i] = cyc;
                end
            end
            if (ferr_o[i]) begin
                ferr_hi[i]++;
                if (!ferr_prev[i]) ferr_rise[i]++;
            end
            if (done_o[i] && ferr_o[i]) both_cnt++;
            done_prev[i] = done_o[i];
            ferr_prev[i] = ferr_o[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int cpb(input int s);
        return (s == 0) ? CPB_B : CPB_S;
    endfunction

    // Drive one 8N1 frame; stop_low > 0 holds the stop bit low for that many bit times.
    task automatic drive_frame(input int s, input logic [7:0] b, input int stop_low);
        rx_pin[s]    = 1'b0;
        start_cyc[s] = cyc;
        wait_cyc(cpb(s));
        for (int i = 0; i < 8; i++) begin
            rx_pin[s] = b[i];
            wait_cyc(cpb(s));
        end
        if (stop_low > 0) begin
            rx_pin[s] = 1'b0;
            wait_cyc(stop_low * cpb(s));
        end
        rx_pin[s] = 1'b1;
        wait_cyc(cpb(s));
    endtask

    initial begin
        int exp_lat_b;
        int exp_lat_s;
        int d0;
        logic [7:0] c3;
        exp_lat_b = 2 + HALF_B + 9 * CPB_B + 1;
        exp_lat_s = 2 + HALF_S + 9 * CPB_S + 1;
        c3        = 8'hC3;

        rst_n[0]  = 1'b0;
        rst_n[1]  = 1'b0;
        rx_pin[0] = 1'b1;
        rx_pin[1] = 1'b1;
        wait_cyc(3);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_data%0d", i), 32'(data_o[i]), 32'h00);
            check($sformatf("reset_done%0d", i), 32'(done_o[i]), 32'h0);
            check($sformatf("reset_ferr%0d", i), 32'(ferr_o[i]), 32'h0);
            check($sformatf("reset_busy%0d", i), 32'(busy_o[i]), 32'h0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        wait_cyc(5);

        // Default baud: single frame and latency.
        drive_frame(0, 8'h75, 0);
        wait_cyc(3);
        check("b_75_count", 32'(done_rise[0]), 32'd1);
        check("b_75_data", 32'(data_o[0]), 32'h75);
        check("b_75_latency", 32'(rise_cyc[0] - start_cyc[0] - 1), 32'(exp_lat_b));
        check("b_75_ferr", 32'(ferr_rise[0]), 32'd0);

        // Glitch shorter than half a bit.
        d0 = cyc;
        rx_pin[0] = 1'b0;
        wait_cyc(100);
        check("b_glitch_busy_mid", 32'(busy_o[0]), 32'h1);
        wait_cyc(100);
        rx_pin[0] = 1'b1;
        wait_cyc(245);
        check("b_glitch_busy_end", 32'(busy_o[0]), 32'h0);
        check("b_glitch_done", 32'(done_rise[0]), 32'd1);
        check("b_glitch_ferr", 32'(ferr_rise[0]), 32'd0);
        check("b_glitch_data", 32'(data_o[0]), 32'h75);
        wait_cyc(20);

        // Back-to-back frames with no idle gap.
        drive_frame(0, 8'h00, 0);
        check("b_b2b_first_count", 32'(done_rise[0]), 32'd2);
        check("b_b2b_first_data", 32'(data_o[0]), 32'h00);
        drive_frame(0, 8'hFF, 0);
        wait_cyc(3);
        check("b_b2b_second_count", 32'(done_rise[0]), 32'd3);
        check("b_b2b_second_data", 32'(data_o[0]), 32'hFF);
        check("b_b2b_spacing", 32'(rise_cyc[0] - prev_cyc[0]), 32'(10 * CPB_B));

        // Small baud setting.
        drive_frame(1, 8'h01, 0);
        wait_cyc(3);
        check("s_01_data", 32'(data_o[1]), 32'h01);
        check("s_01_latency", 32'(rise_cyc[1] - start_cyc[1] - 1), 32'(exp_lat_s));
        drive_frame(1, 8'h80, 0);
        wait_cyc(3);
        check("s_80_data", 32'(data_o[1]), 32'h80);
        check("s_80_latency", 32'(rise_cyc[1] - start_cyc[1] - 1), 32'(exp_lat_s));
        check("s_80_count", 32'(done_rise[1]), 32'd2);

        // Framing error, then recovery.
        drive_frame(1, 8'hA5, 0);
        wait_cyc(3);
        check("s_a5_data", 32'(data_o[1]), 32'hA5);
        drive_frame(1, 8'h3C, 2);
        wait_cyc(3);
        check("s_3c_ferr", 32'(ferr_rise[1]), 32'd1);
        check("s_3c_data", 32'(data_o[1]), 32'hA5);
        check("s_3c_done", 32'(done_rise[1]), 32'd3);
        check("s_3c_busy", 32'(busy_o[1]), 32'h0);
        drive_frame(1, 8'h5A, 0);
        wait_cyc(3);
        check("s_5a_data", 32'(data_o[1]), 32'h5A);
        check("s_5a_count", 32'(done_rise[1]), 32'd4);

        // Reset during data bit 4 of 8'hC3.
        rx_pin[1] = 1'b0;
        wait_cyc(CPB_S);
        for (int i = 0; i < 4; i++) begin
            rx_pin[1] = c3[i];
            wait_cyc(CPB_S);
        end
        rx_pin[1] = c3[4];
        wait_cyc(1);
        rst_n[1]  = 1'b0;
        rx_pin[1] = 1'b1;
        wait_cyc(3);
        rst_n[1] = 1'b1;
        check("s_rst_data", 32'(data_o[1]), 32'h00);
        check("s_rst_busy", 32'(busy_o[1]), 32'h0);
        wait_cyc(10 * CPB_S);
        check("s_rst_done", 32'(done_rise[1]), 32'd4);
        check("s_rst_ferr", 32'(ferr_rise[1]), 32'd1);
        drive_frame(1, 8'h81, 0);
        wait_cyc(3);
        check("s_81_data", 32'(data_o[1]), 32'h81);
        check("s_81_count", 32'(done_rise[1]), 32'd5);

        // Strobe shape over the whole run.
        check("both_strobes", 32'(both_cnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("done_width%0d", i), 32'(done_hi[i]), 32'(done_rise[i]));
            check($sformatf("ferr_width%0d", i), 32'(ferr_hi[i]), 32'(ferr_rise[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
8N1 UART receive stage; the downstream consumer of the uart_transmitter serial line.
- Synchronises the asynchronous rx input and detects the start bit.
- Samples each bit at mid-period and reassembles bytes LSB first.
- Delivers each byte with a one-cycle rx_done strobe, and flags bad stop bits.
- Runs on the 100 MHz system clock at the same baud setting as the transmitter (CLKS_PER_BIT=868, i.e. 115200 baud).

Parameters:
CLKS_PER_BIT, 868, system clocks per serial bit; legal range >= 4
DATA_BITS, 8, payload bits per frame; fixed at 8 for this release

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
o_data_byte  output  8  last correctly framed byte; held until the next good frame
rx_done  output  1  one-cycle pulse, o_data_byte valid and new
framing_err  output  1  one-cycle pulse, stop bit sampled low
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, o_data_byte=8'h00, rx_done=0, framing_err=0, rx_busy=0.
  - Both synchroniser flops=1, bit counter=0, clock counter=0.
- Synchroniser: 2-FF chain on rx; rx_s is the second flop output. All decisions use rx_s (2-cycle input latency).
- HALF = (CLKS_PER_BIT-1)/2 (integer divide; 433 at default). The clock counter is wide enough for CLKS_PER_BIT-1.
- State machine:
  - IDLE: rx_busy=0, counter held 0. rx_s==0 -> START.
  - START: counter increments each cycle. When counter==HALF, sample rx_s:
    - rx_s==0 -> DATA, counter=0, bit_idx=0.
    - rx_s==1 -> IDLE (glitch rejected; no strobe).
  - DATA: counter increments. When counter==CLKS_PER_BIT-1, counter=0 and shift_reg[bit_idx]=rx_s (LSB first).
    - bit_idx<7 -> bit_idx++.
    - bit_idx==7 -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s:
    - rx_s==1: o_data_byte<=shift_reg, rx_done<=1 for one cycle, -> IDLE.
    - rx_s==0: framing_err<=1 for one cycle, o_data_byte unchanged, -> BREAK_WAIT.
  - BREAK_WAIT: stays until rx_s==1, then -> IDLE. This prevents a held-low line (break) being taken as a new start.
- Latency: rx_done rises 2 + HALF + 9*CLKS_PER_BIT + 1 cycles after the rx falling edge at the input pin (8248 at default).
  - Bench tolerance is +-1 cycle for pin-to-flop sampling phase.
- Back-to-back frames: IDLE is re-entered in the cycle after the stop sample. A start edge beginning half a bit after the stop-bit midpoint is caught with no lost frame.
- rx_done and framing_err are registered outputs, never asserted together, and de-assert the cycle after assertion.
- Reset mid-frame aborts immediately: no strobe, partial byte discarded, o_data_byte cleared to 00.
- No overrun detection: a consumer that misses a rx_done strobe loses that byte. o_data_byte is overwritten on each good frame.

Decomposition:
- Shared package uart_pkg:
  - receiver state encoding (IDLE, START, DATA, STOP, BREAK_WAIT; 3-bit localparams);
  - DATA_BITS=8;
  - default CLKS_PER_BIT=868, shared with uart_transmitter.
- One natural sub-module: sync_2ff (parameterised reset value, here 1). Reusable for any asynchronous input.

Test Plan:
- Loopback: uart_transmitter (CLKS_PER_BIT=868) tx -> rx, send 8'b01110101 -> one rx_done pulse ~8248 cycles after the start edge, o_data_byte=8'h75, framing_err never high.
- Glitch: rx driven low for 200 cycles then high -> no rx_done, no framing_err, rx_busy returns to 0 by cycle ~436, o_data_byte unchanged.
- Framing error: after a good 8'hA5, send frame 8'h3C with the stop bit forced low for 2 bit times -> framing_err one pulse, o_data_byte stays 8'hA5, no rx_done. After the line returns high, next frame 8'h5A -> rx_done, o_data_byte=8'h5A.
- Back-to-back: transmitter sends 8'h00 then 8'hFF with zero idle gap -> two rx_done pulses about 10*868 cycles apart, bytes 00 then FF in order.
- Reset mid-frame: assert reset low for 3 cycles during data bit 4 of 8'hC3 -> no strobe, o_data_byte=00, rx_busy=0. A subsequent frame 8'h81 is received correctly.
- Small parameter: CLKS_PER_BIT=4, bytes 8'h01 and 8'h80 -> correct bytes, rx_done latency 2+1+36+1 cycles.
